// File: rtl/matmul_sched_pkg.sv
// Shared types and helpers for the matmul engine scheduler.
// MATMUL_SCHED_TIMEOUT_EN adds the ABORT state used by the watchdog.
package matmul_sched_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int SEL_W       = $clog2(NUM_REQ_DEF);

`ifdef MATMUL_SCHED_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_FINISH,
      S_ABORT
   } sched_state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_FINISH
   } sched_state_t;
`endif

   function automatic logic [31:0] onehot2bin(input logic [31:0] i_oh);
      logic [31:0] v_bin;
      logic [31:0] v_tmp;
      v_bin = '0;
      for (int i = 0; i < 32; i++) begin
         v_tmp = i_oh >> i;
         if (v_tmp[0]) begin
            v_bin = v_bin | 32'(i);
         end
      end
      return v_bin;
   endfunction

endpackage

// File: rtl/matmul_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr.
// Rotate right by ptr, isolate the lowest set bit, rotate back.
module matmul_sched_rr_arbiter
   import matmul_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_valid
);

   logic [NUM_REQ-1:0] w_rot;
   logic [NUM_REQ-1:0] w_first;

   assign w_rot   = NUM_REQ'({i_req, i_req} >> i_ptr);
   assign w_first = w_rot & (~w_rot + NUM_REQ'(1));
   assign o_gnt   = NUM_REQ'({w_first, w_first} >> (NUM_REQ - int'(i_ptr)));
   assign o_valid = |i_req;

endmodule

// File: rtl/matmul_sched.sv
// Round-robin scheduler sharing one matmul engine among NUM_REQ requesters.
// Define MATMUL_SCHED_TIMEOUT_EN to enable the RUN watchdog and ABORT path.
module matmul_sched
   import matmul_sched_pkg::*;
#(
   parameter int NUM_REQ        = NUM_REQ_DEF,
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic [NUM_REQ-1:0]         i_req,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [NUM_REQ-1:0]         o_job_done,
   output logic [NUM_REQ-1:0]         o_job_err,
   output logic [$clog2(NUM_REQ)-1:0] o_mem_sel,
   output logic                       o_busy,
   output logic                       o_mm_start,
   input  logic                       i_mm_done,
   output logic                       o_mm_reset
);

   localparam int SB = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("matmul_sched: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
   end

   sched_state_t       r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_done;
   logic [SB-1:0]      r_sel;
   logic [SB-1:0]      r_ptr;
   logic               r_busy;
   logic               r_start;
   logic               r_mm_reset;

   logic [NUM_REQ-1:0] w_win;
   logic               w_win_vld;
   logic [SB-1:0]      w_win_sel;
   logic [SB-1:0]      w_ptr_nxt;
   logic               w_done_ok;

   matmul_sched_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (SB)
   ) u_arb (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_win),
      .o_valid (w_win_vld)
   );

   assign w_win_sel = SB'(onehot2bin(32'(w_win)));
   assign w_ptr_nxt = (r_sel == SB'(NUM_REQ - 1)) ? '0 : r_sel + SB'(1);
   // done is still stale while the start pulse is on the wire
   assign w_done_ok = i_mm_done & ~r_start;

`ifdef MATMUL_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);

   logic [WD_W-1:0]    r_wdog;
   logic               r_ab_last;
   logic [NUM_REQ-1:0] r_err;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_done     <= '0;
         r_err      <= '0;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_busy     <= 1'b0;
         r_start    <= 1'b0;
         r_mm_reset <= 1'b1;
         r_wdog     <= '0;
         r_ab_last  <= 1'b0;
      end else begin
         r_start    <= 1'b0;
         r_done     <= '0;
         r_err      <= '0;
         r_mm_reset <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_grant <= w_win;
                  r_sel   <= w_win_sel;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_start <= 1'b1;
               r_wdog  <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_done_ok) begin
                  r_done  <= r_grant;
                  r_grant <= '0;
                  r_sel   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_FINISH;
               end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  r_mm_reset <= 1'b1;
                  r_ab_last  <= 1'b0;
                  r_state    <= S_ABORT;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            S_ABORT: begin
               if (!r_ab_last) begin
                  r_mm_reset <= 1'b1;
                  r_ab_last  <= 1'b1;
                  r_err      <= r_grant;
                  r_grant    <= '0;
                  r_sel      <= '0;
                  r_ptr      <= w_ptr_nxt;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_job_err = r_err;
`else
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_done     <= '0;
         r_sel      <= '0;
         r_ptr      <= '0;
         r_busy     <= 1'b0;
         r_start    <= 1'b0;
         r_mm_reset <= 1'b1;
      end else begin
         r_start    <= 1'b0;
         r_done     <= '0;
         r_mm_reset <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_grant <= w_win;
                  r_sel   <= w_win_sel;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_start <= 1'b1;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_done_ok) begin
                  r_done  <= r_grant;
                  r_grant <= '0;
                  r_sel   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_FINISH;
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_job_err = '0;
`endif

   assign o_grant    = r_grant;
   assign o_job_done = r_done;
   assign o_mem_sel  = r_sel;
   assign o_busy     = r_busy;
   assign o_mm_start = r_start;
   assign o_mm_reset = r_mm_reset;

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched with a simple engine model.
// Timeout scenario runs only when MATMUL_SCHED_TIMEOUT_EN is defined.
module tb_matmul_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] grant;
   logic [3:0] jdone;
   logic [3:0] jerr;
   logic [1:0] sel;
   logic       busy;
   logic       start;
   logic       mm_done = 1'b0;
   logic       mmrst;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   int         run_len = 20;
   int         eng_cnt = 0;
   logic       eng_run = 1'b0;

   always #5 clk = ~clk;

   matmul_sched #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_req      (req),
      .o_grant    (grant),
      .o_job_done (jdone),
      .o_job_err  (jerr),
      .o_mem_sel  (sel),
      .o_busy     (busy),
      .o_mm_start (start),
      .i_mm_done  (mm_done),
      .o_mm_reset (mmrst)
   );

   // engine: done drops on start, rises run_len cycles later; run_len 0 hangs
   always @(posedge clk) begin
      if (mmrst === 1'b1) begin
         mm_done <= 1'b0;
         eng_run <= 1'b0;
         eng_cnt <= 0;
      end else if (start === 1'b1) begin
         mm_done <= 1'b0;
         eng_run <= (run_len != 0);
         eng_cnt <= run_len;
      end else if (eng_run) begin
         if (eng_cnt <= 1) begin
            mm_done <= 1'b1;
            eng_run <= 1'b0;
         end else begin
            eng_cnt <= eng_cnt - 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_end(input int budget, output int cyc, output bit low);
      cyc = 0;
      low = 1'b0;
      while (cyc < budget) begin
         tick();
         cyc++;
         if (!mm_done) low = 1'b1;
         if (jdone != 0 || jerr != 0) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_end: no job_done/job_err within %0d cycles", budget);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0;
      repeat (3) tick();
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rst_grant got %b want 0000", grant); end
      checks++; if (jdone !== 4'b0) begin errors++; $display("FAIL rst_done got %b want 0000", jdone); end
      checks++; if (jerr !== 4'b0) begin errors++; $display("FAIL rst_err got %b want 0000", jerr); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", start); end
      checks++; if (mmrst !== 1'b1) begin errors++; $display("FAIL rst_mmrst got %b want 1", mmrst); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (mmrst !== 1'b1) begin errors++; $display("FAIL mmrst_hold got %b want 1", mmrst); end
      tick();
      checks++; if (mmrst !== 1'b0) begin errors++; $display("FAIL mmrst_release got %b want 0", mmrst); end
   endtask

   task automatic test_single();
      int cyc;
      bit low;
      logic [3:0] exp;
      run_len = 20;
      req = 4'b0100;
      exp_q.push_back(4'b0100);
      tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", grant); end
      checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_sel got %0d want 2", sel); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_early got %b want 0", start); end
      tick();
      checks++; if (start !== 1'b1) begin errors++; $display("FAIL single_start got %b want 1", start); end
      tick();
      checks++; if (start !== 1'b0) begin errors++; $display("FAIL single_start_len got %b want 0", start); end
      wait_end(100, cyc, low);
      exp = exp_q.pop_front();
      checks++; if (jdone !== exp) begin errors++; $display("FAIL single_done got %b want %b", jdone, exp); end
      checks++; if (cyc < 20) begin errors++; $display("FAIL single_latency got %0d want >=20", cyc); end
      req = '0;
      tick();
      checks++; if (jdone !== 4'b0) begin errors++; $display("FAIL single_done_len got %b want 0000", jdone); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL single_grant_end got %b want 0000", grant); end
   endtask

   task automatic test_fairness();
      int cyc;
      bit low;
      int njobs;
      int extra;
      logic [3:0] exp;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      run_len = 6;
      njobs = 0;
      extra = 0;
      for (int k = 0; k < 8; k++) exp_q.push_back(4'b0001 << (k % 4));
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_end(60, cyc, low);
         if (jdone != 0) njobs++;
         exp = exp_q.pop_front();
         checks++;
         if (jdone !== exp) begin
            errors++;
            $display("FAIL fair_order job %0d got %b want %b", k, jdone, exp);
         end
      end
      req = '0;
      repeat (20) begin
         tick();
         if (jdone != 0) extra++;
      end
      checks++; if (njobs != 8) begin errors++; $display("FAIL fair_count got %0d want 8", njobs); end
      checks++; if (extra != 0) begin errors++; $display("FAIL fair_extra got %0d want 0", extra); end
   endtask

   task automatic test_stale_done();
      int cyc;
      bit low;
      logic [3:0] exp;
      run_len = 15;
      req = 4'b0010;
      exp_q.push_back(4'b0010);
      wait_end(100, cyc, low);
      exp = exp_q.pop_front();
      checks++; if (jdone !== exp) begin errors++; $display("FAIL stale_done got %b want %b", jdone, exp); end
      checks++; if (low !== 1'b1) begin errors++; $display("FAIL stale_drop got %b want 1", low); end
      checks++; if (cyc < 15) begin errors++; $display("FAIL stale_early got %0d want >=15", cyc); end
      req = '0;
      tick();
   endtask

   task automatic test_drop_mid_job();
      int cyc;
      bit low;
      logic [3:0] exp;
      run_len = 30;
      req = 4'b1000;
      exp_q.push_back(4'b1000);
      tick();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_grant got %b want 1000", grant); end
      repeat (5) tick();
      req = '0;
      wait_end(100, cyc, low);
      exp = exp_q.pop_front();
      checks++; if (jdone !== exp) begin errors++; $display("FAIL drop_done got %b want %b", jdone, exp); end
      tick();
      req = 4'b0110;
      exp_q.push_back(4'b0010);
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_next_grant got %b want 0010", grant); end
      wait_end(100, cyc, low);
      exp = exp_q.pop_front();
      checks++; if (jdone !== exp) begin errors++; $display("FAIL drop_next_done got %b want %b", jdone, exp); end
      req = '0;
      tick();
   endtask

   task automatic test_reset_mid_job();
      int cyc;
      bit low;
      int extra;
      logic [3:0] exp;
      run_len = 40;
      extra = 0;
      req = 4'b0100;
      tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rmj_grant got %b want 0100", grant); end
      repeat (11) tick();
      rst = 1'b1;
      tick();
      checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rmj_grant_clr got %b want 0000", grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmj_busy got %b want 0", busy); end
      checks++; if (mmrst !== 1'b1) begin errors++; $display("FAIL rmj_mmrst got %b want 1", mmrst); end
      checks++; if (jdone !== 4'b0) begin errors++; $display("FAIL rmj_done got %b want 0000", jdone); end
      rst = 1'b0;
      req = '0;
      repeat (50) begin
         tick();
         if (jdone != 0) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL rmj_no_done got %0d want 0", extra); end
      run_len = 8;
      req = 4'b1111;
      exp_q.push_back(4'b0001);
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmj_ptr got %b want 0001", grant); end
      wait_end(60, cyc, low);
      exp = exp_q.pop_front();
      checks++; if (jdone !== exp) begin errors++; $display("FAIL rmj_after_done got %b want %b", jdone, exp); end
      req = '0;
      tick();
   endtask

`ifdef MATMUL_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      int n;
      bit low;
      logic [3:0] exp;
      run_len = 0;
      req = 4'b0011;
      exp_q.push_back(4'b0010);
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", grant); end
      n = 0;
      while (mmrst !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++; if (n < 64 || n >= 200) begin errors++; $display("FAIL to_wait got %0d want 64..199", n); end
      checks++; if (jerr !== 4'b0) begin errors++; $display("FAIL to_err_early got %b want 0000", jerr); end
      tick();
      exp = exp_q.pop_front();
      checks++; if (mmrst !== 1'b1) begin errors++; $display("FAIL to_mmrst2 got %b want 1", mmrst); end
      checks++; if (jerr !== exp) begin errors++; $display("FAIL to_err got %b want %b", jerr, exp); end
      run_len = 10;
      req = 4'b0001;
      tick();
      checks++; if (mmrst !== 1'b0) begin errors++; $display("FAIL to_mmrst_end got %b want 0", mmrst); end
      checks++; if (jerr !== 4'b0) begin errors++; $display("FAIL to_err_len got %b want 0000", jerr); end
      exp_q.push_back(4'b0001);
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_next_grant got %b want 0001", grant); end
      wait_end(60, cyc, low);
      exp = exp_q.pop_front();
      checks++; if (jdone !== exp) begin errors++; $display("FAIL to_next_done got %b want %b", jdone, exp); end
      req = '0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_stale_done();
      test_drop_mid_job();
      test_reset_mid_job();
`ifdef MATMUL_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
